// File: rtl/ft_tx_pkg.sv
// Shared types and constants for the FT600 TX arbiter and its helpers.
package ft_tx_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_e;

  // Width of the channel field in the header word.
  localparam int CH_W = 4;

  // The length field sits at the bottom of the header word.
  // The channel field sits directly above it, starting at bit LEN_W.
  localparam int HDR_LEN_LSB = 0;

  // Filler used to complete a packet whose source stalled out.
  localparam logic [15:0] DEFAULT_PAD_WORD = 16'hDEAD;

endpackage

// File: rtl/rr_pick.sv
// Stateless round-robin selector: finds the first set request bit after
// the given pointer, wrapping at N. The caller owns the pointer register.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[IW'((int'(ptr_i) + i) % N)]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin arbiter sharing the FT600 TX path between packet sources.
// Each packet goes out as a header word followed by its payload words; a
// source that stalls too long has its packet completed with pad words.
module ft_tx_arbiter
  import ft_tx_pkg::*;
#(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    LEN_W      = 12,
  parameter int                    TIMEOUT    = 1024,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD   = DATA_WIDTH'(DEFAULT_PAD_WORD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_REQ-1:0]            src_valid,
  output logic [NUM_REQ-1:0]            src_ready,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_full,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            timeout_err,
  output logic                          busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(TIMEOUT);

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rrPtr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [STALL_W-1:0] stall_q;

  logic                  pickFound;
  logic [IDX_W-1:0]      pickIdx;
  logic [LEN_W-1:0]      pickLen;
  logic                  srcValidG;
  logic [DATA_WIDTH-1:0] srcDataG;
  logic                  writeHeader;
  logic                  xferPayload;
  logic                  writePad;
  logic                  stallCycle;
  logic                  stallHit;
  logic                  lastWord;

  rr_pick #(
    .N (NUM_REQ),
    .IW(IDX_W)
  ) u_pick (
    .req_i  (req_valid),
    .ptr_i  (rrPtr_q),
    .found_o(pickFound),
    .idx_o  (pickIdx)
  );

  // Select the length of the candidate and the data/valid of the granted source.
  always_comb begin
    pickLen   = '0;
    srcValidG = 1'b0;
    srcDataG  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickIdx == IDX_W'(i)) pickLen = req_len[i*LEN_W +: LEN_W];
      if (grant_q == IDX_W'(i)) begin
        srcValidG = src_valid[i];
        srcDataG  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Per-cycle events; back-pressure never counts as a source stall.
  always_comb begin
    writeHeader = (state_q == HEADER) && !tx_full;
    xferPayload = (state_q == PAYLOAD) && srcValidG && !tx_full;
    writePad    = (state_q == PAD) && !tx_full;
    stallCycle  = (state_q == PAYLOAD) && !srcValidG && !tx_full;
    stallHit    = stallCycle && (stall_q == STALL_W'(TIMEOUT - 1));
    lastWord    = (writeHeader && (len_q == '0)) ||
                  ((xferPayload || writePad) && (cnt_q == LEN_W'(1)));
  end

  // Drive the TX port, source handshake and event pulses from the current state.
  always_comb begin
    tx_en       = writeHeader || xferPayload || writePad;
    tx_data     = '0;
    src_ready   = '0;
    req_done    = '0;
    timeout_err = '0;
    busy        = (state_q != IDLE);
    case (state_q)
      HEADER: begin
        tx_data[HDR_LEN_LSB +: LEN_W] = len_q;
        tx_data[LEN_W +: CH_W]        = CH_W'(grant_q);
      end
      PAYLOAD: begin
        tx_data            = srcDataG;
        src_ready[grant_q] = !tx_full;
      end
      PAD:     tx_data = PAD_WORD;
      default: tx_data = '0;
    endcase
    if (lastWord) req_done[grant_q] = 1'b1;
    if (stallHit) timeout_err[grant_q] = 1'b1;
  end

  // Packet framing state machine with round-robin grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= IDX_W'(NUM_REQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickFound) begin
            grant_q <= pickIdx;
            len_q   <= pickLen;
            rrPtr_q <= pickIdx;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (writeHeader) begin
            if (len_q == '0) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= len_q;
              stall_q <= '0;
              state_q <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xferPayload) begin
            cnt_q   <= cnt_q - LEN_W'(1);
            stall_q <= '0;
            if (cnt_q == LEN_W'(1)) state_q <= IDLE;
          end else if (stallHit) begin
            state_q <= PAD;
          end else if (stallCycle) begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end
        PAD: begin
          if (writePad) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
